// File: rtl/risc_chk_pkg.sv
// Shared types for the Risc32 step checker: check kinds, table entry layout, FSM states.
package risc_chk_pkg;

  localparam int CHK_XLEN  = 32;
  localparam int CHK_TAG_W = 8;

  typedef enum logic [1:0] {
    CHK_SKIP = 2'd0,
    CHK_REG  = 2'd1,
    CHK_MEM  = 2'd2,
    CHK_PC   = 2'd3
  } chk_kind_e;

  // Bit layout of one table entry; the RAM stores it flat as {kind, tag, data}.
  typedef struct packed {
    chk_kind_e              kind;
    logic [CHK_TAG_W-1:0]   tag;
    logic [CHK_XLEN-1:0]    data;
  } chk_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } chk_state_e;

endpackage

// File: rtl/chk_expect_ram.sv
// Expected-result table: one synchronous write port, one asynchronous read port.
module chk_expect_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 42,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/risc_step_checker.sv
// Single-steps the Risc32 core via cpu_step and checks each step's writeback / next-PC
// against the expected table, keeping pass/fail statistics and first-fail capture.
//
// state | meaning
// IDLE  | no run in progress, done=0
// STEP  | cpu_step high, current step compared combinationally, result registered
// EVAL  | counters updated, decide next step or finish
// DONE  | run finished, done/pass held until next start
module risc_step_checker
  import risc_chk_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tbl_we,
  input  logic [$clog2(DEPTH)-1:0]  tbl_addr,
  input  logic [2+TAG_W+XLEN-1:0]   tbl_wdata,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_steps,
  input  logic                      stop_on_fail,
  input  logic                      abort,
  output logic                      cpu_step,
  input  logic                      wb_reg_we,
  input  logic [TAG_W-1:0]          wb_reg_addr,
  input  logic [XLEN-1:0]           wb_reg_data,
  input  logic                      wb_mem_we,
  input  logic [TAG_W-1:0]          wb_mem_addr,
  input  logic [XLEN-1:0]           wb_mem_data,
  input  logic [XLEN-1:0]           pc_next,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          step_idx,
  output logic [CNT_W-1:0]          fail_cnt,
  output logic [CNT_W-1:0]          first_fail_idx,
  output logic [XLEN-1:0]           first_fail_obs
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + TAG_W + XLEN;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  chk_state_e state, state_d;

  logic [EW-1:0]    entry;
  chk_kind_e        e_kind;
  logic [TAG_W-1:0] e_tag;
  logic [XLEN-1:0]  e_data;

  logic [CNT_W-1:0] n_q, n_eff, idx_inc;
  logic             sof_q;
  logic             mis_c, mis_q;
  logic [XLEN-1:0]  obs_c, obs_q;
  logic             start_ok;

  chk_expect_ram #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (tbl_we & ~busy),
    .waddr (tbl_addr),
    .wdata (tbl_wdata),
    .raddr (step_idx[AW-1:0]),
    .rdata (entry)
  );

  assign e_kind  = chk_kind_e'(entry[EW-1 -: 2]);
  assign e_tag   = entry[XLEN +: TAG_W];
  assign e_data  = entry[XLEN-1:0];

  assign busy     = (state == STEP) || (state == EVAL);
  assign start_ok = start & ~abort & ~busy;
  assign n_eff    = (num_steps > DEPTH_C) ? DEPTH_C : num_steps;
  assign idx_inc  = step_idx + CNT_W'(1);

  always_comb begin
    mis_c = 1'b0;
    obs_c = '0;
    case (e_kind)
      CHK_REG: begin
        obs_c = wb_reg_we ? wb_reg_data : '0;
        mis_c = !(wb_reg_we && wb_reg_addr == e_tag && wb_reg_data == e_data);
      end
      CHK_MEM: begin
        obs_c = wb_mem_we ? wb_mem_data : '0;
        mis_c = !(wb_mem_we && wb_mem_addr == e_tag && wb_mem_data == e_data);
      end
      CHK_PC: begin
        obs_c = pc_next;
        mis_c = (pc_next != e_data);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state;
    cpu_step = 1'b0;
    case (state)
      IDLE, DONE: if (start_ok) state_d = (n_eff == '0) ? DONE : STEP;
      STEP: begin
        cpu_step = 1'b1;
        state_d  = abort ? IDLE : EVAL;
      end
      EVAL: begin
        if (abort)                                   state_d = IDLE;
        else if (idx_inc == n_q || (mis_q && sof_q)) state_d = DONE;
        else                                         state_d = STEP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      step_idx       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_obs <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      n_q            <= '0;
      sof_q          <= 1'b0;
      mis_q          <= 1'b0;
      obs_q          <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            step_idx       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_obs <= '0;
            n_q            <= n_eff;
            sof_q          <= stop_on_fail;
            done           <= (n_eff == '0);
            pass           <= (n_eff == '0);
          end
        end
        STEP: begin
          mis_q <= mis_c;
          obs_q <= obs_c;
        end
        EVAL: begin
          if (!abort) begin
            step_idx <= idx_inc;
            if (mis_q) begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
              if (fail_cnt == '0) begin
                first_fail_idx <= step_idx;
                first_fail_obs <= obs_q;
              end
            end
            if (state_d == DONE) begin
              done <= 1'b1;
              pass <= !mis_q && (fail_cnt == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_step_checker.sv
// Scoreboard bench for risc_step_checker with a small trace model of Risc32 test program 1.
module tb_risc_step_checker;
  import risc_chk_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic                     clk = 0;
  logic                     rst_n = 0;
  logic                     tbl_we = 0;
  logic [$clog2(DEPTH)-1:0] tbl_addr = '0;
  logic [2+TAG_W+XLEN-1:0]  tbl_wdata = '0;
  logic                     start = 0;
  logic [CNT_W-1:0]         num_steps = '0;
  logic                     stop_on_fail = 0;
  logic                     abort = 0;
  logic                     cpu_step;
  logic                     wb_reg_we, wb_mem_we;
  logic [TAG_W-1:0]         wb_reg_addr, wb_mem_addr;
  logic [XLEN-1:0]          wb_reg_data, wb_mem_data, pc_next;
  logic                     busy, done, pass;
  logic [CNT_W-1:0]         step_idx, fail_cnt, first_fail_idx;
  logic [XLEN-1:0]          first_fail_obs;

  risc_step_checker #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .start(start), .num_steps(num_steps), .stop_on_fail(stop_on_fail), .abort(abort),
    .cpu_step(cpu_step),
    .wb_reg_we(wb_reg_we), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data),
    .wb_mem_we(wb_mem_we), .wb_mem_addr(wb_mem_addr), .wb_mem_data(wb_mem_data),
    .pc_next(pc_next), .busy(busy), .done(done), .pass(pass), .step_idx(step_idx),
    .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx), .first_fail_obs(first_fail_obs)
  );

  always #5 clk = ~clk;

  // Core trace model: step k of program 1; steps 12..14 are BEQ/BNE/JMP (pc 13, 14, 0).
  int k = 0;
  always @(posedge clk) begin
    if (start)         k <= 0;
    else if (cpu_step) k <= k + 1;
  end

  always_comb begin
    wb_reg_we = 0; wb_reg_addr = '0; wb_reg_data = '0;
    wb_mem_we = 0; wb_mem_addr = '0; wb_mem_data = '0;
    pc_next = XLEN'(k + 1);
    case (k)
      0:  begin wb_reg_we = 1; wb_reg_addr = 8'd0; wb_reg_data = 32'd1; end
      1:  begin wb_reg_we = 1; wb_reg_addr = 8'd1; wb_reg_data = 32'd2; end
      2:  begin wb_reg_we = 1; wb_reg_addr = 8'd2; wb_reg_data = 32'd3; end
      3:  begin wb_mem_we = 1; wb_mem_addr = 8'd2; wb_mem_data = 32'd3; end
      14: pc_next = 32'd0;
      default: ;
    endcase
  end

  typedef struct {
    bit p;
    int fc, si, ffi, ffo, pulses;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  bit   done_q = 0, start_q = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: counts cpu_step pulses per run and scores each completed run.
  always @(negedge clk) begin
    if (start) pulses = 0;
    else if (cpu_step) pulses++;
    if (done && (!done_q || start_q)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pass", pass, e.p);
        chk("fail_cnt", fail_cnt, e.fc);
        chk("step_idx", step_idx, e.si);
        chk("first_fail_idx", first_fail_idx, e.ffi);
        chk("first_fail_obs", first_fail_obs, e.ffo);
        chk("cpu_step_pulses", pulses, e.pulses);
      end
    end
    done_q  = done;
    start_q = start;
  end

  function automatic logic [2+TAG_W+XLEN-1:0] ent(chk_kind_e kd, int tag, int data);
    return {kd, TAG_W'(tag), XLEN'(data)};
  endfunction

  task automatic tbl_write(input int a, input logic [2+TAG_W+XLEN-1:0] w);
    @(posedge clk); #1;
    tbl_we = 1; tbl_addr = 4'(a); tbl_wdata = w;
    @(posedge clk); #1;
    tbl_we = 0;
  endtask

  task automatic expect_run(input bit p, input int fc, si, ffi, ffo, pl);
    exp_t e;
    e.p = p; e.fc = fc; e.si = si; e.ffi = ffi; e.ffo = ffo; e.pulses = pl;
    q.push_back(e);
  endtask

  task automatic start_run(input int n, input bit sof);
    @(posedge clk); #1;
    num_steps = CNT_W'(n); stop_on_fail = sof; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cpu_step", cpu_step, 0);
    chk("rst_step_idx", step_idx, 0);
    @(negedge clk); rst_n = 1;

    // Program 1 table, clean run.
    tbl_write(0, ent(CHK_REG, 0, 1));
    tbl_write(1, ent(CHK_REG, 1, 2));
    tbl_write(2, ent(CHK_REG, 2, 3));
    tbl_write(3, ent(CHK_MEM, 2, 3));
    expect_run(1, 0, 4, 0, 0, 4);
    start_run(4, 0); wait_done();

    // Entry 2 wrong; run to end, then stop on first fail.
    tbl_write(2, ent(CHK_REG, 2, 4));
    expect_run(0, 1, 4, 2, 3, 4);
    start_run(4, 0); wait_done();
    expect_run(0, 1, 3, 2, 3, 3);
    start_run(4, 1); wait_done();

    // Write in the same idle cycle as start lands before the run reads it.
    expect_run(1, 0, 4, 0, 0, 4);
    @(posedge clk); #1;
    tbl_we = 1; tbl_addr = 4'd2; tbl_wdata = ent(CHK_REG, 2, 3);
    num_steps = 4; stop_on_fail = 0; start = 1;
    @(posedge clk); #1;
    tbl_we = 0; start = 0;
    wait_done();

    // Write while busy is dropped; the rerun must still pass.
    expect_run(1, 0, 4, 0, 0, 4);
    start_run(4, 0);
    tbl_we = 1; tbl_addr = 4'd0; tbl_wdata = ent(CHK_REG, 0, 99);
    @(posedge clk); #1; tbl_we = 0;
    wait_done();
    expect_run(1, 0, 4, 0, 0, 4);
    start_run(4, 0); wait_done();

    // Branch/jump next-PC checks.
    for (int i = 0; i < 16; i++) tbl_write(i, ent(CHK_SKIP, 0, 0));
    tbl_write(12, ent(CHK_PC, 0, 13));
    tbl_write(13, ent(CHK_PC, 0, 14));
    tbl_write(14, ent(CHK_PC, 0, 0));
    expect_run(1, 0, 15, 0, 0, 15);
    start_run(15, 0); wait_done();
    tbl_write(12, ent(CHK_PC, 0, 12));
    expect_run(0, 1, 15, 12, 13, 15);
    start_run(15, 0); wait_done();

    // n = 0: done on the next cycle, no steps.
    expect_run(1, 0, 0, 0, 0, 0);
    start_run(0, 0);
    @(negedge clk);
    chk("n0_done_next_cycle", done, 1);
    chk("n0_no_busy", busy, 0);

    // num_steps beyond DEPTH clamps to DEPTH.
    tbl_write(12, ent(CHK_PC, 0, 13));
    expect_run(1, 0, 16, 0, 0, 16);
    start_run(31, 0); wait_done();

    // Abort during the second STEP.
    start_run(4, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_step2", cpu_step, 1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_step_idx", step_idx, 1);
    @(negedge clk);
    chk("abort_pulses", pulses, 2);

    // Abort and start together while idle: no run.
    @(posedge clk); #1;
    abort = 1; start = 1; num_steps = 4;
    @(posedge clk); #1;
    abort = 0; start = 0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_cpu_step", cpu_step, 0);

    // Async reset mid-run.
    start_run(4, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_step", cpu_step, 0);
    chk("midrst_step_idx", step_idx, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    @(negedge clk); rst_n = 1;

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
